sd_param_loader: RTL and testbench
==================================

# sd_param_loader

Upstream parameter-fetch stage for the autotest harness. On a start pulse it reads one 512-byte SD block through the sdspihost byte interface. It assembles the leading bytes into the two UUT input vectors and drains the rest of the block so the host returns to idle. Both vectors are presented to the UUT together, on completion.

## Interface
- INPUT_SIZE_1, 32, width of input_to_UUT_1; B1 = ceil(INPUT_SIZE_1/8) bytes
- INPUT_SIZE_2, 32, width of input_to_UUT_2; B2 = ceil(INPUT_SIZE_2/8) bytes; B1+B2 ≤ 512 (elaboration check)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- block_addr_in  in  32  SD block address, captured on accepted start
- loading  out  1  high from accepted start until DONE/ERROR exit
- done  out  1  one-cycle pulse: new vectors valid
- err  out  1  sticky error; cleared by next accepted start or rst
- input_to_UUT_1  out  INPUT_SIZE_1  parameter vector 1
- input_to_UUT_2  out  INPUT_SIZE_2  parameter vector 2
- spi_busy  in  1  host busy
- spi_err  in  1  host error
- spi_data_out  in  8  byte from host, valid when busy falls
- spi_r_block  out  1  one-cycle block-read request
- spi_r_byte  out  1  one-cycle next-byte request
- spi_block_addr  out  32  registered copy of block_addr_in

## Operation
- States: IDLE, REQ_BLK, WAIT_HI, WAIT_LO, CAPTURE, REQ_BYTE, DONE, ERROR.
- IDLE: when start=1, capture the address, clear err, clear shift registers, byte_cnt=0, go to REQ_BLK.
- REQ_BLK: waits for spi_busy=0. It then asserts spi_r_block for exactly one cycle and goes to WAIT_HI.
- REQ_BYTE: waits for spi_busy=0. It then asserts spi_r_byte for exactly one cycle and goes to WAIT_HI.
- WAIT_HI: waits for spi_busy=1, then goes to WAIT_LO. WAIT_LO: waits for spi_busy=0, then goes to CAPTURE.
- CAPTURE: samples spi_data_out, then increments byte_cnt (10-bit, 0..511).
  - byte_cnt < B1: shift into sr1 MSB-first, sr1 = {sr1, byte} truncated to B1*8 bits.
  - B1 ≤ byte_cnt < B1+B2: shift into sr2 in the same way.
  - Later bytes are discarded (drain).
  - Exit: byte_cnt==511 goes to DONE; otherwise goes to REQ_BYTE.
- The block read delivers byte 0. Each r_byte delivers the next byte. Totals: 1 r_block plus 511 r_byte per load.
- DONE: copies the low INPUT_SIZE_1 bits of sr1 to input_to_UUT_1 and the low INPUT_SIZE_2 bits of sr2 to input_to_UUT_2. In the same cycle it pulses done, drops loading and returns to IDLE.
  - The extra high bits of the first byte of each field are discarded.
  - Output vectors change only in this cycle.
- spi_err=1 in any non-IDLE state goes to ERROR. ERROR sets err, drops loading, leaves the output vectors unchanged, and returns to IDLE next cycle.
- start outside IDLE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, byte_cnt 0, sr1/sr2 0.
- spi_r_block and spi_r_byte are registered and never high in the same cycle. They are never asserted while spi_busy=1.
- From a start with the host idle: spi_r_block is high in cycle +2 (IDLE→REQ_BLK edge, then the request edge).
- Per byte, after busy falls: CAPTURE 1 cycle, REQ_BYTE with r_byte high 1 cycle, then WAIT_HI.
- done rises one cycle after the CAPTURE of byte 511. loading falls in that same cycle.
- If busy pulses high and low before the loader reaches WAIT_HI, the byte is missed. The host guarantees busy stays high for at least 2 cycles after a request.
- Error precedence: spi_err outranks the busy transitions in the same cycle.
- Async reset mid-load: every output returns to 0 immediately, and no done pulse is generated.

## Test plan
- INPUT_SIZE_1=INPUT_SIZE_2=32; block bytes 01 23 45 67 89 AB CD EF, then 504×00 → input_to_UUT_1=0x01234567, input_to_UUT_2=0x89ABCDEF. Expect 1 r_block, 511 r_byte and exactly one done; spi_block_addr=block_addr_in (e.g. 0x00000010).
- INPUT_SIZE_1=12, INPUT_SIZE_2=8; bytes FA BC 5E → input_to_UUT_1=0xABC, input_to_UUT_2=0x5E. Outputs stay at their previous values until the done cycle.
- spi_err asserted during byte 100 → err=1, loading=0, no done, previous vectors retained. A subsequent start clears err and completes normally.
- start re-pulsed at bytes 3 and 200 → ignored; the request count is still 1+511.
- rst asserted asynchronously at byte 300 → all outputs 0 before the next clock edge. A following start loads correctly from byte 0.
- spi_busy already 1 when start arrives → spi_r_block is held off until busy=0, then pulses for one cycle only.

Source files
------------

// File: rtl/sd_param_loader.sv
// Parameter-fetch stage: reads one 512-byte SD block via the sdspihost byte
// interface, packs the leading bytes into two UUT vectors and drains the rest.
module sd_param_loader #(
    parameter int INPUT_SIZE_1 = 32,
    parameter int INPUT_SIZE_2 = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             block_addr_in,
    output logic                    loading,
    output logic                    done,
    output logic                    err,
    output logic [INPUT_SIZE_1-1:0] input_to_UUT_1,
    output logic [INPUT_SIZE_2-1:0] input_to_UUT_2,
    input  logic                    spi_busy,
    input  logic                    spi_err,
    input  logic [7:0]              spi_data_out,
    output logic                    spi_r_block,
    output logic                    spi_r_byte,
    output logic [31:0]             spi_block_addr
);

    localparam int B1 = (INPUT_SIZE_1 + 7) / 8;
    localparam int B2 = (INPUT_SIZE_2 + 7) / 8;
    localparam int W1 = B1 * 8;
    localparam int W2 = B2 * 8;
    localparam logic [9:0] LAST_BYTE = 10'd511;
    localparam logic [9:0] END_SR1   = 10'(B1);
    localparam logic [9:0] END_SR2   = 10'(B1 + B2);

    generate
        if (INPUT_SIZE_1 < 1 || INPUT_SIZE_2 < 1 || B1 + B2 > 512) begin : g_size_check
            $error("sd_param_loader: both vectors must fit in one 512-byte block");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, REQ_BLK, WAIT_HI, WAIT_LO, CAPTURE, REQ_BYTE, DONE, ERROR
    } state_t;

    state_t         state;
    logic [9:0]     byte_cnt;
    logic [W1-1:0]  sr1, sr1_nxt;
    logic [W2-1:0]  sr2, sr2_nxt;

    // Shift-register update for the byte being captured; also feeds the
    // output vectors directly so byte 511 can land in sr2 and still appear with done.
    always_comb begin
        sr1_nxt = sr1;
        sr2_nxt = sr2;
        if (byte_cnt < END_SR1)
            sr1_nxt = W1'({sr1, spi_data_out});
        else if (byte_cnt < END_SR2)
            sr2_nxt = W2'({sr2, spi_data_out});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            byte_cnt       <= '0;
            sr1            <= '0;
            sr2            <= '0;
            loading        <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            input_to_UUT_1 <= '0;
            input_to_UUT_2 <= '0;
            spi_r_block    <= 1'b0;
            spi_r_byte     <= 1'b0;
            spi_block_addr <= '0;
        end else begin
            spi_r_block <= 1'b0;
            spi_r_byte  <= 1'b0;
            done        <= 1'b0;
            // Host error wins over any busy edge seen in the same cycle.
            if (spi_err && state != IDLE && state != DONE && state != ERROR) begin
                state   <= ERROR;
                err     <= 1'b1;
                loading <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            spi_block_addr <= block_addr_in;
                            err            <= 1'b0;
                            loading        <= 1'b1;
                            sr1            <= '0;
                            sr2            <= '0;
                            byte_cnt       <= '0;
                            state          <= REQ_BLK;
                        end
                    end
                    REQ_BLK: begin
                        if (!spi_busy) begin
                            spi_r_block <= 1'b1;
                            state       <= WAIT_HI;
                        end
                    end
                    REQ_BYTE: begin
                        if (!spi_busy) begin
                            spi_r_byte <= 1'b1;
                            state      <= WAIT_HI;
                        end
                    end
                    WAIT_HI: if (spi_busy)  state <= WAIT_LO;
                    WAIT_LO: if (!spi_busy) state <= CAPTURE;
                    CAPTURE: begin
                        sr1 <= sr1_nxt;
                        sr2 <= sr2_nxt;
                        if (byte_cnt == LAST_BYTE) begin
                            input_to_UUT_1 <= sr1_nxt[INPUT_SIZE_1-1:0];
                            input_to_UUT_2 <= sr2_nxt[INPUT_SIZE_2-1:0];
                            done           <= 1'b1;
                            loading        <= 1'b0;
                            state          <= DONE;
                        end else begin
                            byte_cnt <= byte_cnt + 10'd1;
                            state    <= REQ_BYTE;
                        end
                    end
                    DONE:    state <= IDLE;
                    ERROR:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_param_loader.sv
// Bench for sd_param_loader: a 32/32 and a 12/8 instance share one SD host
// model; a block-level model predicts every output at each falling edge.
module tb_sd_param_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] block_addr_in = '0;
    logic        spi_err = 1'b0;
    logic        h_busy = 1'b0;
    logic        ext_busy = 1'b0;
    logic        spi_busy;
    logic [7:0]  spi_data_out = '0;
    assign spi_busy = h_busy | ext_busy;

    logic        a_loading, a_done, a_err, a_rblk, a_rbyte;
    logic [31:0] a_v1, a_v2, a_addr;
    logic        b_loading, b_done, b_err, b_rblk, b_rbyte;
    logic [11:0] b_v1;
    logic [7:0]  b_v2;
    logic [31:0] b_addr;

    always #5 clk = ~clk;

    sd_param_loader #(.INPUT_SIZE_1(32), .INPUT_SIZE_2(32)) dut_a (
        .clk(clk), .rst(rst), .start(start), .block_addr_in(block_addr_in),
        .loading(a_loading), .done(a_done), .err(a_err),
        .input_to_UUT_1(a_v1), .input_to_UUT_2(a_v2),
        .spi_busy(spi_busy), .spi_err(spi_err), .spi_data_out(spi_data_out),
        .spi_r_block(a_rblk), .spi_r_byte(a_rbyte), .spi_block_addr(a_addr));

    sd_param_loader #(.INPUT_SIZE_1(12), .INPUT_SIZE_2(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .block_addr_in(block_addr_in),
        .loading(b_loading), .done(b_done), .err(b_err),
        .input_to_UUT_1(b_v1), .input_to_UUT_2(b_v2),
        .spi_busy(spi_busy), .spi_err(spi_err), .spi_data_out(spi_data_out),
        .spi_r_block(b_rblk), .spi_r_byte(b_rbyte), .spi_block_addr(b_addr));

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem [512];
    int          h_idx = 0, h_cnt = 0, h_len = 3, err_idx = -1;
    int          m_phase = 0, done_cd = 0;
    logic        m_loading = 0, m_done = 0, m_err = 0;
    logic [31:0] m_addr = '0;
    logic [63:0] m_v1a = '0, m_v2a = '0, m_v1b = '0, m_v2b = '0;
    int          n_blk_a = 0, n_byte_a = 0, n_blk_b = 0, n_byte_b = 0;
    logic        saw_done = 0, saw_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Field value = leading bytes concatenated MSB-first, cut to the vector width.
    function automatic logic [63:0] field(input int off, input int nb, input int w);
        logic [63:0] v = '0;
        for (int i = 0; i < nb; i++) v = (v << 8) | 64'(mem[off + i]);
        return v & ((64'd1 << w) - 64'd1);
    endfunction

    task automatic fill(input logic [63:0] head, input int nhead, input bit rnd);
        for (int i = 0; i < 512; i++)
            mem[i] = (i < nhead) ? head[63 - 8*i -: 8] : (rnd ? 8'($urandom) : 8'h00);
    endtask

    task automatic compare();
        chk("a_loading", 64'(a_loading), 64'(m_loading));
        chk("a_done",    64'(a_done),    64'(m_done));
        chk("a_err",     64'(a_err),     64'(m_err));
        chk("a_vec1",    64'(a_v1),      m_v1a);
        chk("a_vec2",    64'(a_v2),      m_v2a);
        chk("a_addr",    64'(a_addr),    64'(m_addr));
        chk("b_loading", 64'(b_loading), 64'(m_loading));
        chk("b_done",    64'(b_done),    64'(m_done));
        chk("b_err",     64'(b_err),     64'(m_err));
        chk("b_vec1",    64'(b_v1),      m_v1b);
        chk("b_vec2",    64'(b_v2),      m_v2b);
        chk("b_addr",    64'(b_addr),    64'(m_addr));
        chk("a_req_both", 64'(a_rblk & a_rbyte), 64'd0);
        chk("b_req_both", 64'(b_rblk & b_rbyte), 64'd0);
        chk("a_req_busy", 64'((a_rblk | a_rbyte) & spi_busy), 64'd0);
        chk("b_req_busy", 64'((b_rblk | b_rbyte) & spi_busy), 64'd0);
    endtask

    // SD host: busy for h_len cycles per request, data presented as busy falls.
    task automatic host();
        if (a_rblk)  n_blk_a++;
        if (a_rbyte) n_byte_a++;
        if (b_rblk)  n_blk_b++;
        if (b_rbyte) n_byte_b++;
        spi_err = 1'b0;
        if (h_busy) begin
            if (h_cnt > 1) h_cnt--;
            else begin
                h_busy = 1'b0;
                if (h_idx == err_idx) spi_err = 1'b1;
                else begin
                    spi_data_out = mem[h_idx];
                    if (h_idx == 511) done_cd = 2;
                end
            end
        end else if (a_rblk) begin
            h_busy = 1'b1; h_cnt = h_len; h_idx = 0;
        end else if (a_rbyte) begin
            h_busy = 1'b1; h_cnt = h_len; h_idx++;
        end
    endtask

    // Predicts outputs for the next falling edge from what the next rising edge sees.
    task automatic model();
        m_done = 1'b0;
        if (m_phase == 2) m_phase = 0;
        else if (m_phase == 0) begin
            if (start) begin
                m_phase = 1; m_loading = 1'b1; m_err = 1'b0; m_addr = block_addr_in;
                n_blk_a = 0; n_byte_a = 0; n_blk_b = 0; n_byte_b = 0;
            end
        end else if (spi_err) begin
            m_phase = 2; m_err = 1'b1; m_loading = 1'b0; done_cd = 0;
        end else if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) begin
                m_phase = 2; m_done = 1'b1; m_loading = 1'b0;
                m_v1a = field(0, 4, 32);
                m_v2a = field(4, 4, 32);
                m_v1b = field(0, 2, 12);
                m_v2b = field(2, 1, 8);
                chk("a_n_rblock", 64'(n_blk_a),  64'd1);
                chk("a_n_rbyte",  64'(n_byte_a), 64'd511);
                chk("b_n_rblock", 64'(n_blk_b),  64'd1);
                chk("b_n_rbyte",  64'(n_byte_b), 64'd511);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst) begin
            h_busy = 1'b0; spi_err = 1'b0; h_idx = 0; h_cnt = 0; done_cd = 0;
            m_phase = 0; m_loading = 1'b0; m_done = 1'b0; m_err = 1'b0; m_addr = '0;
            m_v1a = '0; m_v2a = '0; m_v1b = '0; m_v2b = '0;
        end
        saw_done = a_done;
        saw_err  = a_err;
        compare();
        if (!rst) begin
            host();
            model();
        end
        @(posedge clk);
        #2;
    endtask

    task automatic wait_end();
        bit hit = 0;
        for (int i = 0; i < 6000 && !hit; i++) begin
            tick();
            hit = saw_done | saw_err;
        end
        chk("wait_end_timeout", 64'(hit), 64'd1);
    endtask

    task automatic wait_idx(input int k);
        bit hit = 0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            tick();
            hit = (h_idx == k) && h_busy;
        end
        chk("wait_idx_timeout", 64'(hit), 64'd1);
    endtask

    task automatic pulse_start(input logic [31:0] addr);
        block_addr_in = addr;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_a_loading", 64'(a_loading), 64'd0);
        chk("rst_a_vec1",    64'(a_v1),      64'd0);
        chk("rst_a_addr",    64'(a_addr),    64'd0);
        chk("rst_b_done",    64'(b_done),    64'd0);
        chk("rst_a_rblk",    64'(a_rblk),    64'd0);

        // Basic load, block request timing
        fill(64'h0123456789ABCDEF, 8, 1'b0);
        h_len = 3;
        pulse_start(32'h0000_0010);
        chk("t1_rblk_cyc1", 64'(a_rblk),    64'd0);
        chk("t1_load_cyc1", 64'(a_loading), 64'd1);
        tick();
        chk("t1_rblk_cyc2", 64'(a_rblk),    64'd1);
        wait_end();
        chk("t1_a_vec1", 64'(a_v1),   64'h0123_4567);
        chk("t1_a_vec2", 64'(a_v2),   64'h89AB_CDEF);
        chk("t1_b_vec1", 64'(b_v1),   64'h123);
        chk("t1_b_vec2", 64'(b_v2),   64'h45);
        chk("t1_addr",   64'(a_addr), 64'h10);

        // Odd widths, random drain bytes, vectors held until done
        fill(64'hFABC5E0000000000, 8, 1'b1);
        h_len = 2;
        pulse_start(32'h0000_0abc);
        wait_idx(50);
        chk("t2_b_vec1_held", 64'(b_v1), 64'h123);
        wait_end();
        chk("t2_a_vec1", 64'(a_v1), 64'hFABC_5E00);
        chk("t2_b_vec1", 64'(b_v1), 64'hABC);
        chk("t2_b_vec2", 64'(b_v2), 64'h5E);

        // Host error at byte 100, then a clean retry
        fill(64'd0, 0, 1'b1);
        h_len = 3;
        err_idx = 100;
        pulse_start(32'h0000_1000);
        wait_end();
        chk("t3_err",     64'(a_err),     64'd1);
        chk("t3_loading", 64'(a_loading), 64'd0);
        chk("t3_a_vec1",  64'(a_v1),      64'hFABC_5E00);
        err_idx = -1;
        pulse_start(32'h0000_1001);
        chk("t3_err_clr", 64'(a_err), 64'd0);
        wait_end();

        // Start re-pulsed mid-load must be ignored
        fill(64'd0, 0, 1'b1);
        pulse_start(32'h0000_2000);
        wait_idx(3);
        pulse_start(32'hDEAD_BEEF);
        wait_idx(200);
        pulse_start(32'hDEAD_BEEF);
        wait_end();
        chk("t4_addr", 64'(a_addr), 64'h2000);

        // Asynchronous reset mid-load, then reload from byte 0
        pulse_start(32'h0000_3000);
        wait_idx(300);
        rst = 1'b1;
        #1;
        chk("t5_loading", 64'(a_loading), 64'd0);
        chk("t5_a_vec1",  64'(a_v1),      64'd0);
        chk("t5_b_vec2",  64'(b_v2),      64'd0);
        chk("t5_addr",    64'(a_addr),    64'd0);
        chk("t5_rbyte",   64'(a_rbyte),   64'd0);
        chk("t5_err",     64'(a_err),     64'd0);
        tick();
        rst = 1'b0;
        fill(64'h0123456789ABCDEF, 8, 1'b0);
        pulse_start(32'h0000_0020);
        wait_end();
        chk("t5_reload_vec1", 64'(a_v1),   64'h0123_4567);
        chk("t5_reload_addr", 64'(a_addr), 64'h20);

        // Host already busy when start arrives
        fill(64'hFABC5E0000000000, 8, 1'b1);
        ext_busy = 1'b1;
        pulse_start(32'h0000_4000);
        repeat (8) tick();
        chk("t6_rblk_held", 64'(a_rblk),    64'd0);
        chk("t6_loading",   64'(a_loading), 64'd1);
        ext_busy = 1'b0;
        wait_end();
        chk("t6_b_vec1", 64'(b_v1), 64'hABC);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
